lin_slave_responder: RTL and testbench

//  LIN slave-side frame engine, the responder for the master node's header/response scheduling.

---
 rtl/lin_pkg.sv | 54 +++++
 rtl/lin_slave_responder_cks.sv | 29 ++
 rtl/lin_slave_responder.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_lin_slave_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lin_pkg.sv
// Shared constants, state encoding and ID-derived helpers for the LIN slave responder.
package lin_pkg;

    localparam logic [9:0] LIN_BREAK_WORD   = 10'h000;
    localparam logic [9:0] LIN_SYNC_WORD    = 10'h2AA;
    localparam int         LIN_RESP_TIMEOUT = 30;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_CKS     = 2;
    localparam int ERR_BIT     = 3;
    localparam int ERR_TIMEOUT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TX_DATA,
        ST_TX_CKS,
        ST_RX_DATA,
        ST_RX_CKS,
        ST_COMMIT
    } lin_state_e;

    typedef enum logic [1:0] {
        DIR_IGNORE = 2'b00,
        DIR_PUB    = 2'b01,
        DIR_SUB    = 2'b10,
        DIR_RSVD   = 2'b11
    } lin_dir_e;

    // Returns {P1, P0} for a 6-bit frame ID.
    function automatic logic [1:0] pid_parity(input logic [5:0] id);
        return {~(id[1] ^ id[3] ^ id[4] ^ id[5]), id[0] ^ id[1] ^ id[2] ^ id[4]};
    endfunction

    function automatic logic [3:0] frame_len(input logic [5:0] id);
        if (!id[5])
            return 4'd2;
        else if (!id[4])
            return 4'd4;
        else
            return 4'd8;
    endfunction

    function automatic logic is_classic(input logic [5:0] id);
        return (id == 6'd60) || (id == 6'd61);
    endfunction

    function automatic logic [9:0] enc_byte(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/lin_slave_responder_cks.sv
// LIN checksum accumulator: seeded with PID (enhanced) or zero (classic), one byte per cycle.
module lin_checksum_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [7:0] seed,
    input  logic       add,
    input  logic [7:0] add_byte,
    output logic [7:0] result
);

    logic [7:0] sum_q;
    logic [8:0] raw_sum;

    assign raw_sum = {1'b0, sum_q} + {1'b0, add_byte};

    // End-around carry: a sum above 255 wraps to sum - 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sum_q <= '0;
        else if (init)
            sum_q <= seed;
        else if (add)
            sum_q <= raw_sum[7:0] + {7'd0, raw_sum[8]};
    end

    assign result = ~sum_q;

endmodule

// File: rtl/lin_slave_responder.sv
// LIN slave frame engine: header decode, published response with echo readback,
// subscribed response buffered and committed only after a good checksum.
//
//  state    | meaning
//  IDLE     | waiting for a break word
//  SYNC     | break seen, expecting the 0x55 sync word
//  PID      | expecting the protected identifier
//  TX_DATA  | presenting publish byte idx, then waiting for its echo
//  TX_CKS   | presenting the checksum word, then waiting for its echo
//  RX_DATA  | collecting subscribed bytes into the local buffer
//  RX_CKS   | comparing the received checksum with the computed one
//  COMMIT   | streaming the buffered bytes to the RX memory port
module lin_slave_responder
    import lin_pkg::*;
#(
    parameter logic [9:0] BREAK_WORD   = LIN_BREAK_WORD,
    parameter logic [9:0] SYNC_WORD    = LIN_SYNC_WORD,
    parameter int         RESP_TIMEOUT = LIN_RESP_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [9:0] rx_word,
    output logic       tx_valid,
    output logic [9:0] tx_word,
    input  logic       tx_ready,
    input  logic       dir_wr_en,
    input  logic [5:0] dir_wr_id,
    input  logic [1:0] dir_wr_val,
    input  logic       pub_wr_en,
    input  logic [2:0] pub_wr_addr,
    input  logic [7:0] pub_wr_data,
    output logic       sub_wr_en,
    output logic [2:0] sub_wr_addr,
    output logic [7:0] sub_wr_data,
    output logic       frame_done,
    output logic [4:0] err_flags,
    input  logic       err_clr,
    output logic       busy
);

    localparam int               TMR_W    = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESP_TIMEOUT - 1);

    lin_state_e state_q, state_d;

    logic [1:0]       dir_tbl [64];
    logic [7:0]       pub_buf [8];
    logic [7:0]       rx_buf  [8];
    logic [3:0]       len_q;
    logic [2:0]       idx_q;
    logic             tx_sent_q;
    logic [9:0]       sent_word_q;
    logic [TMR_W-1:0] tmr_q;
    logic             break_pend_q;
    logic [4:0]       err_q;

    logic       rx_break, rx_frm_err, pid_ok;
    logic       in_tx, in_resp, tx_valid_int, hs;
    logic       tmr_run, tmr_expire, last_idx;
    logic [7:0] rx_byte, cks_result, acc_seed, acc_byte;
    logic [5:0] rx_id;
    logic [9:0] tx_word_int;
    logic       acc_init, acc_add;
    logic [4:0] err_set;
    logic       done, idx_inc, echo_ok, rx_store;

    assign rx_byte      = rx_word[8:1];
    assign rx_id        = rx_byte[5:0];
    assign rx_break     = rx_valid && (rx_word == BREAK_WORD);
    assign rx_frm_err   = rx_valid && !rx_break && (rx_word[0] || !rx_word[9]);
    assign pid_ok       = rx_byte[7:6] == pid_parity(rx_id);
    assign in_tx        = (state_q == ST_TX_DATA) || (state_q == ST_TX_CKS);
    assign in_resp      = in_tx || (state_q == ST_RX_DATA) || (state_q == ST_RX_CKS);
    assign tx_valid_int = in_tx && !tx_sent_q;
    assign hs           = tx_valid_int && tx_ready && !rx_valid;
    assign tmr_run      = in_resp && !tx_valid_int && !rx_valid;
    assign tmr_expire   = tmr_run && (tmr_q == '0);
    assign last_idx     = {1'b0, idx_q} == (len_q - 4'd1);
    assign tx_word_int  = (state_q == ST_TX_DATA) ? enc_byte(pub_buf[idx_q])
                                                  : enc_byte(cks_result);

    assign acc_init = (state_q == ST_PID) && rx_valid;
    assign acc_seed = is_classic(rx_id) ? 8'h00 : rx_byte;
    assign acc_add  = (hs && (state_q == ST_TX_DATA)) || rx_store;
    assign acc_byte = in_tx ? pub_buf[idx_q] : rx_byte;

    lin_checksum_acc u_cks (
        .clk      (clk),
        .reset    (reset),
        .init     (acc_init),
        .seed     (acc_seed),
        .add      (acc_add),
        .add_byte (acc_byte),
        .result   (cks_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        err_set  = '0;
        done     = 1'b0;
        idx_inc  = 1'b0;
        echo_ok  = 1'b0;
        rx_store = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_break)
                    state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (rx_valid && !rx_break) begin
                    if (rx_word == SYNC_WORD) begin
                        state_d = ST_PID;
                    end else begin
                        err_set[ERR_FRAME] = 1'b1;
                        state_d            = ST_IDLE;
                    end
                end
            end
            ST_PID: begin
                if (rx_break) begin
                    state_d = ST_SYNC;
                end else if (rx_frm_err) begin
                    err_set[ERR_FRAME] = 1'b1;
                    state_d            = ST_IDLE;
                end else if (rx_valid) begin
                    if (!pid_ok) begin
                        err_set[ERR_PARITY] = 1'b1;
                        state_d             = ST_IDLE;
                    end else begin
                        case (lin_dir_e'(dir_tbl[rx_id]))
                            DIR_PUB: state_d = ST_TX_DATA;
                            DIR_SUB: state_d = ST_RX_DATA;
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_TX_DATA, ST_TX_CKS: begin
                if (tmr_expire) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_d              = ST_IDLE;
                end else if (rx_break) begin
                    state_d = ST_SYNC;
                end else if (rx_valid) begin
                    // A word before our own handshake cannot be our echo.
                    if (!tx_sent_q || (!rx_frm_err && (rx_word != sent_word_q))) begin
                        err_set[ERR_BIT] = 1'b1;
                        state_d          = ST_IDLE;
                    end else if (rx_frm_err) begin
                        err_set[ERR_FRAME] = 1'b1;
                        state_d            = ST_IDLE;
                    end else begin
                        echo_ok = 1'b1;
                        if (state_q == ST_TX_CKS) begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_inc = 1'b1;
                            if (last_idx)
                                state_d = ST_TX_CKS;
                        end
                    end
                end
            end
            ST_RX_DATA: begin
                if (tmr_expire) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_d              = ST_IDLE;
                end else if (rx_break) begin
                    state_d = ST_SYNC;
                end else if (rx_frm_err) begin
                    err_set[ERR_FRAME] = 1'b1;
                    state_d            = ST_IDLE;
                end else if (rx_valid) begin
                    rx_store = 1'b1;
                    idx_inc  = 1'b1;
                    if (last_idx)
                        state_d = ST_RX_CKS;
                end
            end
            ST_RX_CKS: begin
                if (tmr_expire) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_d              = ST_IDLE;
                end else if (rx_break) begin
                    state_d = ST_SYNC;
                end else if (rx_frm_err) begin
                    err_set[ERR_FRAME] = 1'b1;
                    state_d            = ST_IDLE;
                end else if (rx_valid) begin
                    if (rx_byte == cks_result) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_set[ERR_CKS] = 1'b1;
                        state_d          = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                idx_inc = 1'b1;
                if (last_idx) begin
                    done    = 1'b1;
                    state_d = (break_pend_q || rx_break) ? ST_SYNC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = state_q != ST_IDLE;
        tx_valid    = tx_valid_int;
        tx_word     = tx_valid_int ? tx_word_int : '0;
        sub_wr_en   = state_q == ST_COMMIT;
        sub_wr_addr = sub_wr_en ? idx_q : '0;
        sub_wr_data = sub_wr_en ? rx_buf[idx_q] : '0;
        frame_done  = done;
        err_flags   = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q        <= '0;
            idx_q        <= '0;
            tx_sent_q    <= 1'b0;
            sent_word_q  <= '0;
            tmr_q        <= '0;
            break_pend_q <= 1'b0;
            err_q        <= '0;
        end else begin
            if (acc_init)
                len_q <= frame_len(rx_id);

            if (state_d != state_q)
                idx_q <= '0;
            else if (idx_inc)
                idx_q <= idx_q + 3'd1;

            if ((state_d != state_q) || echo_ok)
                tx_sent_q <= 1'b0;
            else if (hs)
                tx_sent_q <= 1'b1;

            if (hs)
                sent_word_q <= tx_word_int;

            // Down-counter reloaded by bus activity; expiry is tested at zero.
            if (rx_valid)
                tmr_q <= TMR_LOAD;
            else if (tmr_run && (tmr_q != '0))
                tmr_q <= tmr_q - TMR_W'(1);

            if (state_q != ST_COMMIT)
                break_pend_q <= 1'b0;
            else if (rx_break)
                break_pend_q <= 1'b1;

            err_q <= (err_clr ? 5'd0 : err_q) | err_set;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++)
                dir_tbl[i] <= DIR_IGNORE;
            for (int i = 0; i < 8; i++) begin
                pub_buf[i] <= '0;
                rx_buf[i]  <= '0;
            end
        end else begin
            if (dir_wr_en)
                dir_tbl[dir_wr_id] <= dir_wr_val;
            if (pub_wr_en)
                pub_buf[pub_wr_addr] <= pub_wr_data;
            if (rx_store)
                rx_buf[idx_q] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_lin_slave_responder.sv
// Scoreboard bench for lin_slave_responder: expected tx words, sub commits and frame_done
// pulses are queued by the stimulus and consumed by an independent negedge monitor.
module tb_lin_slave_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [9:0] rx_word;
    logic       tx_valid;
    logic [9:0] tx_word;
    logic       tx_ready;
    logic       dir_wr_en;
    logic [5:0] dir_wr_id;
    logic [1:0] dir_wr_val;
    logic       pub_wr_en;
    logic [2:0] pub_wr_addr;
    logic [7:0] pub_wr_data;
    logic       sub_wr_en;
    logic [2:0] sub_wr_addr;
    logic [7:0] sub_wr_data;
    logic       frame_done;
    logic [4:0] err_flags;
    logic       err_clr;
    logic       busy;

    lin_slave_responder dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_word     (rx_word),
        .tx_valid    (tx_valid),
        .tx_word     (tx_word),
        .tx_ready    (tx_ready),
        .dir_wr_en   (dir_wr_en),
        .dir_wr_id   (dir_wr_id),
        .dir_wr_val  (dir_wr_val),
        .pub_wr_en   (pub_wr_en),
        .pub_wr_addr (pub_wr_addr),
        .pub_wr_data (pub_wr_data),
        .sub_wr_en   (sub_wr_en),
        .sub_wr_addr (sub_wr_addr),
        .sub_wr_data (sub_wr_data),
        .frame_done  (frame_done),
        .err_flags   (err_flags),
        .err_clr     (err_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [9:0]  exp_tx[$];
    logic [10:0] exp_sub[$];
    bit          exp_done[$];
    logic [9:0]  mon_w;
    logic [10:0] mon_s;

    function automatic logic [9:0] enc(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (reset) begin
            if (tx_valid && tx_ready) begin
                vectors++;
                if (exp_tx.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_word: unexpected word %h", tx_word);
                end else begin
                    mon_w = exp_tx.pop_front();
                    if (tx_word !== mon_w) begin
                        miscompares++;
                        $display("FAIL tx_word: got %h, expected %h", tx_word, mon_w);
                    end
                end
            end else if (tx_valid && exp_tx.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tx_valid: asserted with word %h but none expected", tx_word);
            end
            if (sub_wr_en) begin
                vectors++;
                if (exp_sub.size() == 0) begin
                    miscompares++;
                    $display("FAIL sub_wr: unexpected write addr %0d data %h", sub_wr_addr, sub_wr_data);
                end else begin
                    mon_s = exp_sub.pop_front();
                    if ({sub_wr_addr, sub_wr_data} !== mon_s) begin
                        miscompares++;
                        $display("FAIL sub_wr: got addr %0d data %h, expected addr %0d data %h",
                                 sub_wr_addr, sub_wr_data, mon_s[10:8], mon_s[7:0]);
                    end
                end
            end
            if (frame_done) begin
                vectors++;
                if (exp_done.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_done: unexpected pulse");
                end else begin
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        rx_word  = w;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic header(input logic [7:0] pid);
        send_word(10'h000);
        send_word(10'h2AA);
        send_word(enc(pid));
    endtask

    task automatic dir_cfg(input logic [5:0] id, input logic [1:0] v);
        dir_wr_id  = id;
        dir_wr_val = v;
        dir_wr_en  = 1'b1;
        tick(1);
        dir_wr_en  = 1'b0;
    endtask

    task automatic pub_cfg(input logic [2:0] a, input logic [7:0] d);
        pub_wr_addr = a;
        pub_wr_data = d;
        pub_wr_en   = 1'b1;
        tick(1);
        pub_wr_en   = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // Bus transmitter model: accept the word, then loop it back (optionally corrupted).
    task automatic serve_tx(input bit corrupt);
        int n;
        logic [9:0] w;
        n = 0;
        while (!tx_valid && n < 60) begin
            tick(1);
            n++;
        end
        if (!tx_valid) begin
            chk("tx_wait", 32'(tx_valid), 32'd1);
            return;
        end
        w        = tx_word;
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        tick(1);
        send_word(corrupt ? (w ^ 10'h002) : w);
    endtask

    task automatic expect_sub(input logic [2:0] a, input logic [7:0] d);
        exp_sub.push_back({a, d});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pub_data [8];

        reset       = 1'b0;
        rx_valid    = 1'b0;
        rx_word     = '0;
        tx_ready    = 1'b0;
        dir_wr_en   = 1'b0;
        dir_wr_id   = '0;
        dir_wr_val  = '0;
        pub_wr_en   = 1'b0;
        pub_wr_addr = '0;
        pub_wr_data = '0;
        err_clr     = 1'b0;
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_word", 32'(tx_word), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        chk("rst_sub_wr_en", 32'(sub_wr_en), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b1;
        tick(1);

        dir_cfg(6'h10, 2'b10);
        dir_cfg(6'h20, 2'b10);
        dir_cfg(6'h3C, 2'b01);

        // Subscribe ID 0x10, enhanced checksum 0x69.
        expect_sub(3'd0, 8'h12);
        expect_sub(3'd1, 8'h34);
        exp_done.push_back(1'b1);
        header(8'h50);
        send_word(enc(8'h12));
        send_word(enc(8'h34));
        send_word(enc(8'h69));
        tick(4);
        chk("sub_ok_err", 32'(err_flags), 32'd0);
        chk("sub_ok_busy", 32'(busy), 32'd0);

        // Same frame, wrong checksum: nothing committed.
        header(8'h50);
        send_word(enc(8'h12));
        send_word(enc(8'h34));
        send_word(enc(8'h68));
        tick(4);
        chk("sub_badcks_err", 32'(err_flags), 32'h04);
        chk("sub_badcks_busy", 32'(busy), 32'd0);
        clear_err();
        chk("err_clr", 32'(err_flags), 32'd0);

        // Subscribe ID 0x20 (length 4), enhanced checksum 0xD5.
        for (int i = 0; i < 4; i++)
            expect_sub(3'(i), 8'(i + 1));
        exp_done.push_back(1'b1);
        header(8'h20);
        for (int i = 0; i < 4; i++)
            send_word(enc(8'(i + 1)));
        send_word(enc(8'hD5));
        tick(6);
        chk("sub4_err", 32'(err_flags), 32'd0);

        // Publish ID 0x3C, classic checksum over an all-zero buffer.
        for (int i = 0; i < 8; i++)
            exp_tx.push_back(10'h200);
        exp_tx.push_back(10'h3FE);
        exp_done.push_back(1'b1);
        header(8'h3C);
        for (int i = 0; i < 9; i++)
            serve_tx(1'b0);
        tick(3);
        chk("pub0_err", 32'(err_flags), 32'd0);
        chk("pub0_busy", 32'(busy), 32'd0);

        // Publish with end-around carry: 0x80+0x80+0x01 -> 0x02, checksum 0xFD.
        pub_data = '{8'h80, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++)
            pub_cfg(3'(i), pub_data[i]);
        for (int i = 0; i < 8; i++)
            exp_tx.push_back(enc(pub_data[i]));
        exp_tx.push_back(enc(8'hFD));
        exp_done.push_back(1'b1);
        header(8'h3C);
        for (int i = 0; i < 9; i++)
            serve_tx(1'b0);
        tick(3);
        chk("pub_carry_err", 32'(err_flags), 32'd0);

        // Publish with the echo of byte 2 corrupted.
        for (int i = 0; i < 3; i++)
            exp_tx.push_back(enc(pub_data[i]));
        header(8'h3C);
        serve_tx(1'b0);
        serve_tx(1'b0);
        serve_tx(1'b1);
        tick(3);
        chk("pub_echo_err", 32'(err_flags), 32'h08);
        chk("pub_echo_busy", 32'(busy), 32'd0);
        chk("pub_echo_txv", 32'(tx_valid), 32'd0);
        clear_err();

        // PID for 0x10 with parity bits 00.
        header(8'h10);
        tick(3);
        chk("parity_err", 32'(err_flags), 32'h02);
        chk("parity_txv", 32'(tx_valid), 32'd0);
        chk("parity_busy", 32'(busy), 32'd0);
        clear_err();

        // Response stalls after one byte.
        header(8'h50);
        send_word(enc(8'h12));
        tick(40);
        chk("timeout_err", 32'(err_flags), 32'h10);
        chk("timeout_busy", 32'(busy), 32'd0);
        clear_err();

        // Recovery with 20-cycle gaps (below the timeout): checksum 0x36.
        expect_sub(3'd0, 8'hAB);
        expect_sub(3'd1, 8'hCD);
        exp_done.push_back(1'b1);
        header(8'h50);
        send_word(enc(8'hAB));
        tick(20);
        send_word(enc(8'hCD));
        tick(20);
        send_word(enc(8'h36));
        tick(4);
        chk("recover_err", 32'(err_flags), 32'd0);

        // Break mid-response restarts the frame without error: checksum 0xF3.
        expect_sub(3'd0, 8'h55);
        expect_sub(3'd1, 8'h66);
        exp_done.push_back(1'b1);
        header(8'h50);
        send_word(enc(8'h12));
        header(8'h50);
        send_word(enc(8'h55));
        send_word(enc(8'h66));
        send_word(enc(8'hF3));
        tick(4);
        chk("abort_err", 32'(err_flags), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);

        // Reset mid-frame: no commit, and the direction table returns to ignore.
        header(8'h50);
        send_word(enc(8'h12));
        send_word(enc(8'h34));
        reset = 1'b0;
        tick(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick(1);
        header(8'h50);
        send_word(enc(8'h12));
        send_word(enc(8'h34));
        send_word(enc(8'h69));
        tick(4);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_err", 32'(err_flags), 32'd0);

        chk("left_tx", 32'(exp_tx.size()), 32'd0);
        chk("left_sub", 32'(exp_sub.size()), 32'd0);
        chk("left_done", 32'(exp_done.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
